median_frame_sequencer: RTL
===========================

// Module: median_frame_sequencer
// PURPOSE
//  Sequences whole image frames through the median filter path: captures each frame pulsed out by the UART receiver,
//  issues it to the median filter over valid/ready, collects the filtered frame, hands it to the UART transmitter.
//  One frame in flight; frames arriving while busy are dropped and counted. Watchdog aborts a stalled filter.
// PARAMETERS
//  R_I 7 / C_I 7 / W_I 8   input image rows, cols, pixel bits; W_IN = R_I*C_I*W_I (localparam)
//  R_O 5 / C_O 5           filtered image rows, cols; W_OUT = R_O*C_O*W_I (localparam)
//  TIMEOUT_CYCLES 4096     max cycles in WAIT_FILT before abort (>=2)
// PORTS
//  clk        in   1      single clock
//  rstn       in   1      reset, synchronous, active-low
//  rx_valid   in   1      one-cycle frame-complete pulse from receiver; no backpressure possible
//  rx_data    in   W_IN   received frame, valid only with rx_valid
//  f_s_valid  out  1      frame to filter valid
//  f_s_ready  in   1      filter accepts frame
//  f_s_data   out  W_IN   frame to filter
//  f_m_valid  in   1      filtered frame valid (filter output)
//  f_m_ready  out  1      sequencer accepts filtered frame
//  f_m_data   in   W_OUT  filtered frame
//  tx_valid   out  1      frame to transmitter valid
//  tx_ready   in   1      transmitter accepts frame
//  tx_data    out  W_OUT  frame to transmitter
//  busy       out  1      state != IDLE
//  err_timeout out 1      one-cycle pulse on watchdog abort
//  frame_cnt  out  16     frames completed to tx, wraps 0xFFFF->0
//  drop_cnt   out  8      frames dropped (overrun), saturates at 0xFF
// BEHAVIOUR
//  Reset (rstn=0 at posedge): state=IDLE; all outputs 0; frame/output regs cleared; watchdog 0. Reset mid-frame abandons frame, no pulses.
//  States: IDLE, ISSUE, WAIT_FILT, SEND_TX.
//   IDLE: rx_valid -> latch rx_data into in_reg, ->ISSUE (f_s_valid=1 next cycle).
//   ISSUE: f_s_valid=1, f_s_data=in_reg stable; on f_s_valid&f_s_ready -> WAIT_FILT, f_s_valid=0 next cycle.
//   WAIT_FILT: f_m_ready=1; on f_m_valid -> latch f_m_data into out_reg, ->SEND_TX, watchdog=0.
//     watchdog increments each WAIT_FILT cycle; reaching TIMEOUT_CYCLES-1 without f_m_valid -> err_timeout=1 one cycle, ->IDLE.
//     f_m_valid in the same cycle as expiry wins: frame accepted, no timeout.
//   SEND_TX: tx_valid=1, tx_data=out_reg stable; on tx_valid&tx_ready -> frame_cnt+1, ->IDLE.
//  f_m_ready is 1 only in WAIT_FILT; f_m_valid outside WAIT_FILT is ignored.
//  Overrun: rx_valid in any state other than IDLE -> drop_cnt+1 (saturating), in-flight frame untouched.
//  Latency: rx_valid at cycle n -> f_s_valid at n+1; f_m_valid at m -> tx_valid at m+1; ready seen same cycle as valid is accepted.
//  Valid outputs never retract before handshake; data registers change only on the latch events above.
//  Back-to-back: SEND_TX handshake -> IDLE; rx_valid in that IDLE cycle is accepted normally.
// STRUCTURE
//  Package median_sys_pkg: state enum seq_state_t {IDLE,ISSUE,WAIT_FILT,SEND_TX}; W_IN/W_OUT helper functions;
//   FRAME_CNT_W=16, DROP_CNT_W=8 constants.
//  Sub-module seq_watchdog (clear/enable/expire counter, $clog2(TIMEOUT_CYCLES) bits); rest single FSM + datapath regs.
// TESTING
//  1 Reset: rstn=0 3 cycles mid-ISSUE -> all outputs 0, busy=0, counters 0 from first cycle after rstn=1.
//  2 Nominal: rx_data=0x01..0x31 pattern, f_s_ready=1, filter returns 0xAA.. after 10 cycles, tx_ready=1 -> tx_data matches, frame_cnt=1, f_s_valid at n+1.
//  3 Backpressure: f_s_ready=0 20 cycles, tx_ready=0 30 cycles -> valids held, data stable, single handshake each, frame_cnt=1.
//  4 Overrun: 3 rx_valid pulses during WAIT_FILT -> drop_cnt=3, original frame delivered; 300 overruns -> drop_cnt=0xFF.
//  5 Timeout: TIMEOUT_CYCLES=16, filter silent -> err_timeout pulse exactly 16 cycles after entering WAIT_FILT, busy=0 next cycle; f_m_valid on cycle 16 -> accepted, no pulse.
//  6 Wrap: preload 0xFFFF frames (force/backdoor) then one frame -> frame_cnt=0x0000.

Source files
------------

// File: rtl/median_frame_sequencer_pkg.sv
// Shared types and helpers for the median filter frame sequencer.
package median_sys_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_FILT = 2'd2,
    SEND_TX   = 2'd3
  } seq_state_t;

  localparam int FRAME_CNT_W = 16;
  localparam int DROP_CNT_W  = 8;

  // Flattened width of the unfiltered input frame.
  function automatic int calc_w_in(input int rows, input int cols, input int pix_w);
    return rows * cols * pix_w;
  endfunction

  // Flattened width of the filtered output frame.
  function automatic int calc_w_out(input int rows, input int cols, input int pix_w);
    return rows * cols * pix_w;
  endfunction

endpackage

// File: rtl/median_frame_sequencer_watchdog.sv
// Watchdog counter for the filter wait phase: counts enabled cycles and
// flags expiry once TIMEOUT_CYCLES-1 is reached.
module seq_watchdog #(
  parameter  int TIMEOUT_CYCLES = 4096,
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Expiry is visible in the same cycle the count reaches its limit.
  always_comb begin
    expire = enable && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  // Next count: clear dominates, otherwise count up while enabled and below the limit.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expire) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/median_frame_sequencer.sv
// Frame sequencer: receiver -> median filter -> transmitter, one frame in
// flight, overrun frames counted and dropped, stalled filter aborted by watchdog.
module median_frame_sequencer
  import median_sys_pkg::*;
#(
  parameter  int R_I            = 7,
  parameter  int C_I            = 7,
  parameter  int W_I            = 8,
  parameter  int R_O            = 5,
  parameter  int C_O            = 5,
  parameter  int TIMEOUT_CYCLES = 4096,
  localparam int W_IN           = calc_w_in(R_I, C_I, W_I),
  localparam int W_OUT          = calc_w_out(R_O, C_O, W_I)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   rx_valid,
  input  logic [W_IN-1:0]        rx_data,
  output logic                   f_s_valid,
  input  logic                   f_s_ready,
  output logic [W_IN-1:0]        f_s_data,
  input  logic                   f_m_valid,
  output logic                   f_m_ready,
  input  logic [W_OUT-1:0]       f_m_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [W_OUT-1:0]       tx_data,
  output logic                   busy,
  output logic                   err_timeout,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic [DROP_CNT_W-1:0]  drop_cnt
);

  seq_state_t             state_q;
  seq_state_t             state_d;
  logic [W_IN-1:0]        in_reg_q;
  logic [W_IN-1:0]        in_reg_d;
  logic [W_OUT-1:0]       out_reg_q;
  logic [W_OUT-1:0]       out_reg_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_d;
  logic [DROP_CNT_W-1:0]  drop_cnt_q;
  logic [DROP_CNT_W-1:0]  drop_cnt_d;
  logic                   err_timeout_q;
  logic                   err_timeout_d;
  logic                   wd_enable;
  logic                   wd_clear;
  logic                   wd_expire;

  // Watchdog runs only while waiting on the filter and restarts from zero on every entry.
  assign wd_enable = (state_q == WAIT_FILT);
  assign wd_clear  = (state_q != WAIT_FILT);

  seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a filter result in the expiry cycle beats the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (rx_valid)  state_d = ISSUE;
      ISSUE:     if (f_s_ready) state_d = WAIT_FILT;
      WAIT_FILT: begin
        if (f_m_valid) begin
          state_d = SEND_TX;
        end else if (wd_expire) begin
          state_d = IDLE;
        end
      end
      SEND_TX:   if (tx_ready)  state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state, so valids never retract.
  always_comb begin
    f_s_valid = (state_q == ISSUE);
    f_m_ready = (state_q == WAIT_FILT);
    tx_valid  = (state_q == SEND_TX);
    busy      = (state_q != IDLE);
  end

  // Frame registers load only on capture events; counters and timeout pulse.
  always_comb begin
    in_reg_d      = in_reg_q;
    out_reg_d     = out_reg_q;
    frame_cnt_d   = frame_cnt_q;
    drop_cnt_d    = drop_cnt_q;
    err_timeout_d = 1'b0;
    if (state_q == IDLE && rx_valid) begin
      in_reg_d = rx_data;
    end
    if (state_q == WAIT_FILT && f_m_valid) begin
      out_reg_d = f_m_data;
    end
    if (state_q == WAIT_FILT && wd_expire && !f_m_valid) begin
      err_timeout_d = 1'b1;
    end
    if (state_q == SEND_TX && tx_ready) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
    if (state_q != IDLE && rx_valid && drop_cnt_q != '1) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  // Datapath and counter registers; reset clears frames so nothing stale leaks out.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      in_reg_q      <= '0;
      out_reg_q     <= '0;
      frame_cnt_q   <= '0;
      drop_cnt_q    <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      in_reg_q      <= in_reg_d;
      out_reg_q     <= out_reg_d;
      frame_cnt_q   <= frame_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign f_s_data    = in_reg_q;
  assign tx_data     = out_reg_q;
  assign frame_cnt   = frame_cnt_q;
  assign drop_cnt    = drop_cnt_q;
  assign err_timeout = err_timeout_q;

endmodule
